alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Multi-cycle, parametrised-width ALU that follows the 4-bit combinational ALU with the same
//  ADD/SUB/logic ops and CO/OVF/Z/N flags. Adds barrel-free iterative shifts/rotate and a
//  shift-add multiply, with registered outputs and a valid/ready handshake on both sides.
//  Sits between the decode/register-read stage and write-back of the multi-cycle datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=4); SHW = $clog2(WIDTH) = shift-amount width
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      op/A/B valid this cycle
//  in_ready   out  1      block can accept an op this cycle
//  op         in   4      operation code (table below)
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B; for shifts, amount = B[SHW-1:0]
//  out_valid  out  1      result and flags valid
//  out_ready  in   1      consumer takes result this cycle
//  out        out  WIDTH  result
//  CO         out  1      carry flag
//  OVF        out  1      signed-overflow flag
//  Z          out  1      out == 0
//  N          out  1      out[WIDTH-1]
//  busy       out  1      state is SHIFT or MUL
// BEHAVIOUR
//  Ops: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 ORR; 4 XOR; 5 BIC A&~B; 6 MOV B; 7 MVN ~B;
//   8 LSL; 9 LSR; 10 ASR; 11 ROR (A by amt); 12 MUL low WIDTH bits of A*B; 13-15 reserved -> out=0.
//  Flags: ADD CO=carry out, SUB CO=1 when no borrow (A>=B unsigned); OVF=signed overflow (ADD/SUB
//   only, else 0). Logic/MOV/MVN/MUL/reserved: CO=0, OVF=0. Shifts: CO=last bit shifted out,
//   0 when amt=0. Z, N are derived from the final out for every op.
//  FSM: IDLE, SHIFT, MUL, DONE. Accept = in_valid && in_ready. A, B, op are latched on accept.
//  in_ready = (state==IDLE) || (state==DONE && out_ready); out_valid = (state==DONE).
//  Accept of ops 0-7, 13-15, or a shift with amt=0 -> DONE at the accept edge (latency 1).
//  Shift with amt=n>0 -> SHIFT. Each cycle moves 1 bit and decrements the counter.
//   DONE after edge k+n (k = accept edge). ASR fills with the original MSB. ROR feeds back bit 0.
//  MUL -> MUL state for WIDTH cycles: add A<<i when B[i], truncate to WIDTH. DONE after edge k+WIDTH.
//  DONE: out and flags are held stable while out_ready=0.
//   out_ready=1 with in_valid=0 -> IDLE.
//   out_ready=1 with in_valid=1 -> new accept in the same edge (back-to-back, 1 op/cycle for latency-1 ops).
//  in_valid while busy is ignored; A/B/op changes during SHIFT/MUL have no effect.
//  Reset (any state, including mid-SHIFT/MUL):
//   next cycle state=IDLE, in_ready=1, out_valid=0, busy=0;
//   out=0, CO=0, OVF=0, Z=0, N=0; counters/partials cleared.
//  Outputs are all registered; no combinational path from A/B/op to out/flags.
//  out/flags are updated only on entry to DONE; their values outside DONE are don't-care except after reset.
// TESTING (WIDTH=8)
//  ADD A=0x7F B=0x01, out_ready=1 -> out_valid 1 cycle after accept; out=0x80 N=1 OVF=1 CO=0 Z=0
//  SUB A=0x05 B=0x05 then back-to-back XOR 0xF0^0x0F -> 0x00 Z=1 CO=1, next cycle 0xFF N=1 CO=0
//  ASR A=0x80 B=7 -> busy=1 for 7 cycles, out_valid after edge k+7; out=0xFF N=1 CO=0
//   LSR A=0x81 B=0 -> latency 1, out=0x81 CO=0
//  MUL A=0x0C B=0x19 -> out_valid after edge k+8; out=0x2C CO=0 OVF=0; in_valid pulses while busy ignored
//  Backpressure: hold out_ready=0 5 cycles after ROR 0x01 by 1 -> out=0x80 CO=1 stable, in_ready=0
//  Reset mid-MUL (cycle 4) -> next cycle out_valid=0 busy=0 in_ready=1 out=0; op 14 -> out=0 Z=1

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, iterative 1-bit/cycle shifts, shift-add multiply.
// Valid/ready on both sides. All results and flags are registered and held in DONE until they are taken.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             CO,
  output logic             OVF,
  output logic             Z,
  output logic             N,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] acc, a_r, b_r;
  logic [SHW-1:0]   cnt;
  logic [1:0]       sh_op;
  logic [SHW-1:0]   amt;
  logic             accept, is_shift, is_mul, long_op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] imm_val, sh_nx, mul_nx, fin_val;
  logic             imm_co, imm_ovf, sh_co, fin_co, fin_ovf, fin_load;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == MUL);
  assign accept    = in_valid && in_ready;
  assign amt       = B[SHW-1:0];
  assign is_shift  = (op[3:2] == 2'b10);
  assign is_mul    = (op == 4'd12);
  assign long_op   = is_mul || (is_shift && amt != '0);
  assign sum_ext   = {1'b0, A} + {1'b0, B};
  assign diff      = A - B;
  assign mul_nx    = acc + (b_r[0] ? a_r : '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul)       state_nx = MUL;
          else if (long_op) state_nx = SHIFT;
          else              state_nx = DONE;
        end else if (state == DONE && out_ready) begin
          state_nx = IDLE;
        end
      end
      SHIFT, MUL: if (cnt == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Single-cycle results; shift ops reach here only with a zero amount.
  always_comb begin
    imm_val = '0;
    imm_co  = 1'b0;
    imm_ovf = 1'b0;
    case (op)
      4'd0: begin
        imm_val = sum_ext[WIDTH-1:0];
        imm_co  = sum_ext[WIDTH];
        imm_ovf = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
      end
      4'd1: begin
        imm_val = diff;
        imm_co  = (A >= B);
        imm_ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      4'd2: imm_val = A & B;
      4'd3: imm_val = A | B;
      4'd4: imm_val = A ^ B;
      4'd5: imm_val = A & ~B;
      4'd6: imm_val = B;
      4'd7: imm_val = ~B;
      4'd8, 4'd9, 4'd10, 4'd11: imm_val = A;
      default: ;
    endcase
  end

  always_comb begin
    sh_nx = acc;
    sh_co = 1'b0;
    case (sh_op)
      2'd0:    {sh_co, sh_nx} = {acc, 1'b0};
      2'd1:    {sh_nx, sh_co} = {1'b0, acc};
      2'd2:    {sh_nx, sh_co} = {acc[MSB], acc};
      default: {sh_nx, sh_co} = {acc[0], acc};
    endcase
  end

  always_comb begin
    fin_load = 1'b0;
    fin_val  = imm_val;
    fin_co   = imm_co;
    fin_ovf  = imm_ovf;
    if (accept && !long_op) begin
      fin_load = 1'b1;
    end else if (state == SHIFT && cnt == '0) begin
      fin_load = 1'b1;
      fin_val  = sh_nx;
      fin_co   = sh_co;
      fin_ovf  = 1'b0;
    end else if (state == MUL && cnt == '0) begin
      fin_load = 1'b1;
      fin_val  = mul_nx;
      fin_co   = 1'b0;
      fin_ovf  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      cnt   <= '0;
      sh_op <= '0;
      out   <= '0;
      CO    <= 1'b0;
      OVF   <= 1'b0;
      Z     <= 1'b0;
      N     <= 1'b0;
    end else begin
      if (accept) begin
        sh_op <= op[1:0];
        a_r   <= A;
        b_r   <= B;
        if (is_mul) begin
          acc <= '0;
          cnt <= SHW'(WIDTH - 1);
        end else begin
          acc <= A;
          cnt <= amt - 1'b1;
        end
      end else if (state == SHIFT) begin
        acc <= sh_nx;
        cnt <= cnt - 1'b1;
      end else if (state == MUL) begin
        // Multiplicand walks left while the multiplier is consumed from its LSB.
        acc <= mul_nx;
        a_r <= a_r << 1;
        b_r <= b_r >> 1;
        cnt <= cnt - 1'b1;
      end
      if (fin_load) begin
        out <= fin_val;
        CO  <= fin_co;
        OVF <= fin_ovf;
        Z   <= (fin_val == '0);
        N   <= fin_val[MSB];
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed literal cases plus randomized traffic against a behavioural model.
module tb_alu_mc;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic         CO, OVF, Z, N, busy;
  logic [3:0]   op;
  logic [W-1:0] A, B, out;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         ovf;
    int           lat;
    int           due;
  } exp_t;
  exp_t q[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .CO(CO), .OVF(OVF), .Z(Z), .N(N), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result, flags and cycles spent in SHIFT/MUL, straight from the op definitions.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output exp_t e);
    int n, t, sa, sb, s;
    n = int'(b[2:0]);
    sa = $signed(a);
    sb = $signed(b);
    e.r = '0; e.co = 1'b0; e.ovf = 1'b0; e.lat = 0; e.due = 0;
    case (o)
      4'd0: begin t = a + b; e.r = t[7:0]; e.co = t[8]; s = sa + sb; e.ovf = (s > 127) || (s < -128); end
      4'd1: begin t = a - b; e.r = t[7:0]; e.co = (a >= b); s = sa - sb; e.ovf = (s > 127) || (s < -128); end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = a ^ b;
      4'd5: e.r = a & ~b;
      4'd6: e.r = b;
      4'd7: e.r = ~b;
      4'd8: begin t = a << n; e.r = t[7:0]; e.co = (n > 0) ? t[8] : 1'b0; e.lat = n; end
      4'd9, 4'd10, 4'd11: begin
        if (o == 4'd9)       t = a >> n;
        else if (o == 4'd10) t = sa >>> n;
        else                 t = (a >> n) | (a << (8 - n));
        e.r = t[7:0];
        if (n > 0) e.co = a[n-1];
        e.lat = n;
      end
      4'd12: begin t = a * b; e.r = t[7:0]; e.lat = W; end
      default: e.r = '0;
    endcase
  endfunction

  // Scoreboard: every cycle, compare handshake/status and (when due) the result against the model.
  initial begin
    exp_t e;
    logic exp_rdy;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        continue;
      end
      exp_rdy = 1'b1;
      if (q.size() > 0) exp_rdy = (cyc >= q[0].due) && out_ready;
      chk("in_ready", in_ready, exp_rdy);
      if (q.size() == 0) begin
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
      end else if (cyc < q[0].due) begin
        chk("pend_out_valid", out_valid, 0);
        chk("pend_busy", busy, q[0].lat > 0);
      end else begin
        chk("out_valid", out_valid, 1);
        chk("busy_done", busy, 0);
        chk("out", out, q[0].r);
        chk("CO", CO, q[0].co);
        chk("OVF", OVF, q[0].ovf);
        chk("Z", Z, q[0].r == 0);
        chk("N", N, q[0].r[W-1]);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        model(op, A, B, e);
        e.due = cyc + 1 + e.lat;
        q.push_back(e);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; A = a; B = b; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("issue_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); A = 8'($urandom); B = 8'($urandom);
  endtask

  // Counts falling edges until out_valid; optionally injects in_valid pulses that must be ignored.
  task automatic wait_out(input bit pulse, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (pulse) begin
        #2;
        in_valid = 1'($urandom); op = 4'($urandom); A = 8'($urandom); B = 8'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    chk("wait_out_valid", out_valid, 1);
  endtask

  initial begin
    exp_t m;
    int   n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", out, 0);
    chk("rst_flags", {CO, OVF, Z, N}, 4'b0000);

    model(4'd12, 8'h0C, 8'h19, m); chk("model_mul", m.r, 8'h2C);
    model(4'd11, 8'h01, 8'h01, m); chk("model_ror", {m.co, m.r}, 9'h180);
    model(4'd10, 8'h80, 8'h07, m); chk("model_asr", {m.co, m.r}, 9'h0FF);
    model(4'd0, 8'h7F, 8'h01, m);  chk("model_add", {m.ovf, m.co, m.r}, 10'h280);

    @(posedge clk); #1;
    issue(4'd0, 8'h7F, 8'h01);
    wait_out(1'b0, n);
    chk("add_lat", n, 1);
    chk("add_out", out, 8'h80);
    chk("add_flags", {CO, OVF, Z, N}, 4'b0101);

    @(posedge clk); #1;
    op = 4'd1; A = 8'h05; B = 8'h05; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready0", in_ready, 1);
    @(posedge clk); #1;
    op = 4'd4; A = 8'hF0; B = 8'h0F;
    @(negedge clk);
    chk("sub_valid", out_valid, 1);
    chk("sub_out", out, 8'h00);
    chk("sub_flags", {CO, Z, N}, 3'b110);
    chk("b2b_ready1", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("xor_valid", out_valid, 1);
    chk("xor_out", out, 8'hFF);
    chk("xor_flags", {CO, Z, N}, 3'b001);

    @(posedge clk); #1;
    issue(4'd10, 8'h80, 8'h07);
    wait_out(1'b0, n);
    chk("asr_lat", n, 8);
    chk("asr_out", out, 8'hFF);
    chk("asr_flags", {CO, N}, 2'b01);

    @(posedge clk); #1;
    issue(4'd9, 8'h81, 8'h00);
    wait_out(1'b0, n);
    chk("lsr0_lat", n, 1);
    chk("lsr0_out", {CO, out}, 9'h081);

    @(posedge clk); #1;
    issue(4'd12, 8'h0C, 8'h19);
    wait_out(1'b1, n);
    chk("mul_lat", n, 9);
    chk("mul_out", out, 8'h2C);
    chk("mul_flags", {CO, OVF}, 2'b00);

    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'd11, 8'h01, 8'h01);
    wait_out(1'b0, n);
    chk("ror_lat", n, 2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_out", {CO, out}, 9'h180);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);

    @(posedge clk); #1;
    issue(4'd12, 8'h0C, 8'h19);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out", out, 0);
    chk("mrst_flags", {CO, OVF, Z, N}, 4'b0000);

    @(posedge clk); #1;
    issue(4'd14, 8'h5A, 8'hA5);
    wait_out(1'b0, n);
    chk("rsv_lat", n, 1);
    chk("rsv_out", out, 0);
    chk("rsv_flags", {CO, OVF, Z, N}, 4'b0010);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      op = 4'($urandom_range(0, 15));
      A  = 8'($urandom);
      B  = 8'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
